// File: rtl/mips_cpu_regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU and load writeback requests into one
// registered write port, with round-robin contention handling and decode hazard flags.
module mips_cpu_regfile_wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        write_enable,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    input  logic [4:0]  query_reg_1,
    input  logic [4:0]  query_reg_2,
    output logic        hazard_1,
    output logic        hazard_2,
    output logic [15:0] conflict_count
);

    typedef enum logic {
        PTR_ALU = 1'b0,
        PTR_MEM = 1'b1
    } ptr_e;

    ptr_e        ptr_q, ptr_d;
    logic        write_enable_q, write_enable_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic [31:0] write_data_q, write_data_d;
    logic [15:0] conflict_count_q, conflict_count_d;
    logic        contend;
    logic        alu_grant;
    logic        mem_grant;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A query hits if any write is in flight or pending for that register; r0 never hazards.
    function automatic logic hazard_of(
        input logic [4:0] q,
        input logic       we,
        input logic [4:0] wr,
        input logic       av,
        input logic [4:0] ar,
        input logic       mv,
        input logic [4:0] mr
    );
        return (q != 5'd0) && ((we && (wr == q)) || (av && (ar == q)) || (mv && (mr == q)));
    endfunction

    always_comb begin
        contend   = alu_valid & mem_valid;
        alu_grant = ~reset & alu_valid & (~mem_valid | (ptr_q == PTR_ALU));
        mem_grant = ~reset & mem_valid & (~alu_valid | (ptr_q == PTR_MEM));
    end

    always_comb begin
        ptr_d            = ptr_q;
        write_enable_d   = 1'b0;
        write_reg_d      = write_reg_q;
        write_data_d     = write_data_q;
        conflict_count_d = conflict_count_q;

        if (contend) begin
            ptr_d            = (ptr_q == PTR_ALU) ? PTR_MEM : PTR_ALU;
            conflict_count_d = sat_inc16(conflict_count_q);
        end

        // Writes to r0 complete the handshake but are dropped here.
        if (alu_grant && (alu_reg != 5'd0)) begin
            write_enable_d = 1'b1;
            write_reg_d    = alu_reg;
            write_data_d   = alu_data;
        end else if (mem_grant && (mem_reg != 5'd0)) begin
            write_enable_d = 1'b1;
            write_reg_d    = mem_reg;
            write_data_d   = mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q            <= PTR_ALU;
            write_enable_q   <= 1'b0;
            write_reg_q      <= 5'd0;
            write_data_q     <= 32'd0;
            conflict_count_q <= 16'd0;
        end else begin
            ptr_q            <= ptr_d;
            write_enable_q   <= write_enable_d;
            write_reg_q      <= write_reg_d;
            write_data_q     <= write_data_d;
            conflict_count_q <= conflict_count_d;
        end
    end

    always_comb begin
        alu_ready      = alu_grant;
        mem_ready      = mem_grant;
        write_enable   = write_enable_q;
        write_reg      = write_reg_q;
        write_data     = write_data_q;
        conflict_count = conflict_count_q;
        hazard_1       = ~reset & hazard_of(query_reg_1, write_enable_q, write_reg_q,
                                            alu_valid, alu_reg, mem_valid, mem_reg);
        hazard_2       = ~reset & hazard_of(query_reg_2, write_enable_q, write_reg_q,
                                            alu_valid, alu_reg, mem_valid, mem_reg);
    end

endmodule

// File: tb/tb_mips_cpu_regfile_wb_arbiter.sv
// Directed bench for the writeback arbiter: handshake, contention, fairness,
// r0 suppression, hazards and mid-operation reset.
module tb_mips_cpu_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        write_enable;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  query_reg_1;
    logic [4:0]  query_reg_2;
    logic        hazard_1;
    logic        hazard_2;
    logic [15:0] conflict_count;

    int checks = 0;
    int errors = 0;

    mips_cpu_regfile_wb_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_reg        (alu_reg),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .mem_valid      (mem_valid),
        .mem_reg        (mem_reg),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .write_enable   (write_enable),
        .write_reg      (write_reg),
        .write_data     (write_data),
        .query_reg_1    (query_reg_1),
        .query_reg_2    (query_reg_2),
        .hazard_1       (hazard_1),
        .hazard_2       (hazard_2),
        .conflict_count (conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        alu_valid   = 1'b0;
        alu_reg     = 5'd0;
        alu_data    = 32'd0;
        mem_valid   = 1'b0;
        mem_reg     = 5'd0;
        mem_data    = 32'd0;
        query_reg_1 = 5'd0;
        query_reg_2 = 5'd0;
        step();
        step();

        // Reset state, with a valid request that must not be granted
        alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'h33;
        #1;
        chk("rst_we",    {31'd0, write_enable}, 32'd0);
        chk("rst_wr",    {27'd0, write_reg},    32'd0);
        chk("rst_wd",    write_data,            32'd0);
        chk("rst_cc",    {16'd0, conflict_count}, 32'd0);
        chk("rst_alu_rdy", {31'd0, alu_ready},  32'd0);
        chk("rst_hz1",   {31'd0, hazard_1},     32'd0);
        step();
        reset = 1'b0; alu_valid = 1'b0;
        step();

        // Single ALU request
        alu_valid = 1'b1; alu_reg = 5'd16; alu_data = 32'd1234567;
        #1;
        chk("single_alu_rdy", {31'd0, alu_ready}, 32'd1);
        chk("single_mem_rdy", {31'd0, mem_ready}, 32'd0);
        step();
        alu_valid = 1'b0;
        #1;
        chk("single_we", {31'd0, write_enable}, 32'd1);
        chk("single_wr", {27'd0, write_reg},    32'd16);
        chk("single_wd", write_data,            32'd1234567);
        step();
        chk("single_we_off", {31'd0, write_enable}, 32'd0);
        chk("single_wr_hold", {27'd0, write_reg},   32'd16);
        chk("single_wd_hold", write_data,           32'd1234567);

        // Contention: ALU first, then MEM
        alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'hAAAA;
        mem_valid = 1'b1; mem_reg = 5'd6; mem_data = 32'h5555;
        #1;
        chk("cont_alu_rdy", {31'd0, alu_ready}, 32'd1);
        chk("cont_mem_rdy", {31'd0, mem_ready}, 32'd0);
        step();
        alu_valid = 1'b0;
        #1;
        chk("cont_mem_rdy2", {31'd0, mem_ready}, 32'd1);
        chk("cont_we1", {31'd0, write_enable}, 32'd1);
        chk("cont_wr1", {27'd0, write_reg},    32'd5);
        chk("cont_wd1", write_data,            32'hAAAA);
        step();
        mem_valid = 1'b0;
        #1;
        chk("cont_we2", {31'd0, write_enable}, 32'd1);
        chk("cont_wr2", {27'd0, write_reg},    32'd6);
        chk("cont_wd2", write_data,            32'h5555);
        chk("cont_cc",  {16'd0, conflict_count}, 32'd1);
        step();
        chk("cont_we_off", {31'd0, write_enable}, 32'd0);

        // Reset mid-operation: accepted transfer must not survive reset
        alu_valid = 1'b1; alu_reg = 5'd16; alu_data = 32'h1111;
        #1;
        chk("rmid_alu_rdy", {31'd0, alu_ready}, 32'd1);
        step();
        reset = 1'b1; alu_valid = 1'b0;
        step();
        alu_valid = 1'b1; alu_reg = 5'd1; mem_valid = 1'b1; mem_reg = 5'd2;
        #1;
        chk("rmid_we",      {31'd0, write_enable},   32'd0);
        chk("rmid_cc",      {16'd0, conflict_count}, 32'd0);
        chk("rmid_alu_rdy0", {31'd0, alu_ready},     32'd0);
        chk("rmid_mem_rdy0", {31'd0, mem_ready},     32'd0);
        step();
        reset = 1'b0;

        // Fairness: six contention cycles alternate starting from ALU
        for (int i = 0; i < 6; i++) begin
            alu_data = 32'(i);
            mem_data = 32'(100 + i);
            #1;
            chk($sformatf("fair_alu_rdy%0d", i), {31'd0, alu_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("fair_mem_rdy%0d", i), {31'd0, mem_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
            step();
            chk($sformatf("fair_we%0d", i), {31'd0, write_enable}, 32'd1);
            chk($sformatf("fair_wr%0d", i), {27'd0, write_reg}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("fair_wd%0d", i), write_data, (i % 2 == 0) ? 32'(i) : 32'(100 + i));
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        #1;
        chk("fair_cc", {16'd0, conflict_count}, 32'd6);

        // Zero register: handshake completes, no write
        mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'hFFFFFFFF; query_reg_1 = 5'd0;
        #1;
        chk("zero_mem_rdy", {31'd0, mem_ready}, 32'd1);
        chk("zero_hz1",     {31'd0, hazard_1},  32'd0);
        step();
        mem_valid = 1'b0;
        #1;
        chk("zero_we",  {31'd0, write_enable}, 32'd0);
        chk("zero_wr",  {27'd0, write_reg},    32'd2);
        chk("zero_wd",  write_data,            32'd105);

        // Hazard tracking through the write cycle
        alu_valid = 1'b1; alu_reg = 5'd20; alu_data = 32'd7;
        query_reg_1 = 5'd20; query_reg_2 = 5'd21;
        #1;
        chk("hz_req_h1", {31'd0, hazard_1}, 32'd1);
        chk("hz_req_h2", {31'd0, hazard_2}, 32'd0);
        step();
        alu_valid = 1'b0;
        #1;
        chk("hz_wr_we", {31'd0, write_enable}, 32'd1);
        chk("hz_wr_h1", {31'd0, hazard_1},     32'd1);
        chk("hz_wr_h2", {31'd0, hazard_2},     32'd0);
        step();
        chk("hz_after_h1", {31'd0, hazard_1}, 32'd0);

        // Same destination from both sides: later grant (MEM) wins
        alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'hA;
        mem_valid = 1'b1; mem_reg = 5'd9; mem_data = 32'hB;
        #1;
        chk("same_alu_rdy", {31'd0, alu_ready}, 32'd1);
        step();
        alu_valid = 1'b0;
        #1;
        chk("same_wd1", write_data, 32'hA);
        chk("same_mem_rdy", {31'd0, mem_ready}, 32'd1);
        step();
        mem_valid = 1'b0;
        #1;
        chk("same_we2", {31'd0, write_enable}, 32'd1);
        chk("same_wr2", {27'd0, write_reg},    32'd9);
        chk("same_wd2", write_data,            32'hB);
        chk("same_cc",  {16'd0, conflict_count}, 32'd7);
        step();
        chk("same_we_off", {31'd0, write_enable}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
